// File: rtl/wb_ram_pipelined.sv
// -----------------------------------------------------------------------------
// wb_ram_pipelined
//
// Wishbone B4 pipelined-mode RAM slave. It serves as the combined instruction
// and data memory of the multi-cycle RISC-V system.
//
// Features:
//   - configurable data width, depth and read latency
//   - one ordered response pipeline shared by reads and writes
//   - out-of-range addresses complete with err instead of ack
//   - dropping i_wb_cyc discards every in-flight response
//   - optional post-reset clear, which zeroes every word while the slave stalls
//
// Ports:
//   i_clk        clock; all logic runs on the rising edge
//   i_rst        asynchronous, active-high reset
//   i_wb_cyc     bus cycle active
//   i_wb_stb     request strobe
//   i_wb_we      1 = write, 0 = read
//   i_wb_addr    byte address; the low lane-select bits are ignored
//   i_wb_data    write data
//   i_wb_sel     byte-lane enables for writes; ignored on reads
//   o_wb_ack     request completed successfully
//   o_wb_err     request completed with error (address out of range)
//   o_wb_stall   slave cannot accept a request this cycle
//   o_wb_data    read data; zero unless a read ack is presented
//   o_init_done  memory clear finished; slave is ready
// -----------------------------------------------------------------------------
module wb_ram_pipelined #(
  parameter int DATA_WIDTH     = 32,
  parameter int MEMORY_DEPTH   = 1024,
  parameter int ADDR_WIDTH     = 32,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_wb_cyc,
  input  logic                    i_wb_stb,
  input  logic                    i_wb_we,
  input  logic [ADDR_WIDTH-1:0]   i_wb_addr,
  input  logic [DATA_WIDTH-1:0]   i_wb_data,
  input  logic [DATA_WIDTH/8-1:0] i_wb_sel,
  output logic                    o_wb_ack,
  output logic                    o_wb_err,
  output logic                    o_wb_stall,
  output logic [DATA_WIDTH-1:0]   o_wb_data,
  output logic                    o_init_done
);

  localparam int SEL_WIDTH = DATA_WIDTH / 8;
  localparam int WORDS     = MEMORY_DEPTH / SEL_WIDTH;
  localparam int LANE_BITS = $clog2(SEL_WIDTH);
  localparam int IDX_W     = (WORDS > 1) ? $clog2(WORDS) : 1;

  // One extra bit, so that the range check still works when ADDR_WIDTH equals
  // $clog2(MEMORY_DEPTH). In that case MEMORY_DEPTH does not fit in ADDR_WIDTH bits.
  localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(MEMORY_DEPTH);
  localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(WORDS - 1);

  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } state_t;

  // Control part of one response-pipeline stage.
  typedef struct packed {
    logic valid;
    logic err;
    logic rd;
  } rsp_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        cnt_q, cnt_d;
  logic                    clear_we;

  logic                    accept;
  logic                    in_range;
  logic [ADDR_WIDTH-1:0]   addr_words;
  logic [IDX_W-1:0]        word_idx;

  logic [DATA_WIDTH-1:0]   mem [WORDS];

  rsp_t                    pipe_q    [READ_LATENCY];
  logic [DATA_WIDTH-1:0]   pipe_data [READ_LATENCY];
  rsp_t                    pipe_last;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  assign o_wb_stall  = (state_q == ST_CLEAR);
  assign o_init_done = (state_q == ST_READY);

  assign accept      = i_wb_cyc && i_wb_stb && !o_wb_stall;
  assign in_range    = ({1'b0, i_wb_addr} < DEPTH_EXT);
  assign addr_words  = i_wb_addr >> LANE_BITS;
  assign word_idx    = addr_words[IDX_W-1:0];
  assign pipe_last   = pipe_q[READ_LATENCY-1];

  // ---------------------------------------------------------------------------
  // Clear / ready FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave it unassigned and infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    clear_we = 1'b0;

    case (state_q)
      ST_CLEAR: begin
        clear_we = 1'b1;
        cnt_d    = cnt_q + IDX_W'(1);
        if (cnt_q == LAST_IDX) begin
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        state_d = ST_READY;
      end
      default: begin
        state_d = ST_READY;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Memory array with registered read (block-RAM style)
  // ---------------------------------------------------------------------------
  // NOTE: the RAM and its read-data registers deliberately have no reset.
  // A reset on them would prevent block-RAM inference. The clear sequence
  // supplies defined contents instead.
  always_ff @(posedge i_clk) begin
    if (clear_we) begin
      mem[cnt_q] <= '0;
    end else if (accept && i_wb_we && in_range) begin
      for (int k = 0; k < SEL_WIDTH; k++) begin
        if (i_wb_sel[k]) begin
          mem[word_idx][8*k +: 8] <= i_wb_data[8*k +: 8];
        end
      end
    end

    // The read happens in the acceptance cycle. A write has already committed
    // at an earlier edge, so a read on the next cycle sees the new data.
    if (accept && !i_wb_we) begin
      pipe_data[0] <= mem[word_idx];
    end
    for (int i = 1; i < READ_LATENCY; i++) begin
      pipe_data[i] <= pipe_data[i-1];
    end
  end

  // ---------------------------------------------------------------------------
  // FSM state, clear counter and the ordered response pipeline
  // ---------------------------------------------------------------------------
  // NOTE: state registers use non-blocking assignments. All of them then update
  // together at the edge, and the shift chain moves exactly one stage per cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      cnt_q     <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_q[i] <= '0;
      end
      o_wb_ack  <= 1'b0;
      o_wb_err  <= 1'b0;
      o_wb_data <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;

      if (!i_wb_cyc) begin
        // The master has abandoned the cycle. Nothing in flight may complete.
        // Writes have already committed to the RAM at their acceptance edge.
        for (int i = 0; i < READ_LATENCY; i++) begin
          pipe_q[i] <= '0;
        end
        o_wb_ack  <= 1'b0;
        o_wb_err  <= 1'b0;
        o_wb_data <= '0;
      end else begin
        pipe_q[0].valid <= accept;
        pipe_q[0].err   <= accept && !in_range;
        pipe_q[0].rd    <= accept && !i_wb_we;
        for (int i = 1; i < READ_LATENCY; i++) begin
          pipe_q[i] <= pipe_q[i-1];
        end

        o_wb_ack  <= pipe_last.valid && !pipe_last.err;
        o_wb_err  <= pipe_last.valid &&  pipe_last.err;
        o_wb_data <= (pipe_last.valid && !pipe_last.err && pipe_last.rd)
                     ? pipe_data[READ_LATENCY-1] : '0;
      end
    end
  end

endmodule
